fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
- Consumer of the branch-condition result.
- Owns the PC and the instruction-fetch request to instruction memory, and drives the IF/ID pipeline register.
- Applies taken branches (brCond plus brTarget from the ID stage) by redirecting the PC and squashing the wrong-path instruction.
- Handles variable-latency memory, pipeline stalls and outstanding requests with a one-entry skid buffer and a small FSM.

Parameters:
ADDR_W, 32, PC and instruction-memory address width
DATA_W, 32, instruction width
RESET_PC, 0, PC value after reset
PC_STEP, 1, PC increment per fetched instruction (word-addressed imem)
NOP_INSTR, 0, value driven on ifInstr when IF/ID holds a bubble
CNT_W, 16, width of the saturating redirect counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
brCond  in  1  branch-taken flag for the instruction currently in ID
brTarget  in  ADDR_W  branch target for the instruction in ID
stall  in  1  hazard stall; IF/ID must hold its contents
imemAck  in  1  one-cycle pulse; imemRdata valid for the address in imemAddr
imemRdata  in  DATA_W  fetched instruction
imemReq  out  1  fetch request; held high with imemAddr stable until imemAck
imemAddr  out  ADDR_W  fetch address (registered)
ifInstr  out  DATA_W  IF/ID instruction
ifPc  out  ADDR_W  IF/ID instruction address
ifValid  out  1  IF/ID holds a real instruction
ifFlush  out  1  registered one-cycle pulse, cycle after a redirect is accepted
redirectCount  out  CNT_W  count of accepted redirects, saturating at all-ones

Behaviour:
- Reset (asynchronous, immediate):
  - pc=RESET_PC, imemAddr=RESET_PC, imemReq=0.
  - ifValid=0, ifInstr=NOP_INSTR, ifPc=0, ifFlush=0, redirectCount=0.
  - Skid buffer empty, state=IDLE.
  - Any outstanding memory request is abandoned; imem tolerates imemReq dropping.
- Redirect acceptance: redirect = brCond & ifValid & ~stall, sampled at the clock edge. brCond is ignored when stall=1 or ifValid=0.
- On an accepted redirect:
  - pc<=brTarget; ifValid<=0; ifInstr<=NOP_INSTR.
  - ifFlush<=1 for exactly one cycle.
  - redirectCount increments unless already saturated.
  - Any skid-buffer contents are discarded.
- States and transitions:
  - IDLE: imemReq=0. Moves to REQ on the first cycle after reset release, with imemAddr=pc.
  - REQ: imemReq=1.
    - ack & redirect: drop rdata; imemAddr<=brTarget; stay in REQ.
    - ack & ~stall & ~redirect: IF/ID<= {rdata, imemAddr, valid}; pc and imemAddr <= imemAddr+PC_STEP; stay in REQ.
    - ack & stall: rdata and address go into the skid buffer; pc<=imemAddr+PC_STEP; go to SKID.
    - ~ack & redirect: go to DRAIN; imemAddr stays unchanged.
    - ~ack & ~stall: IF/ID becomes a bubble (ifValid<=0).
  - DRAIN: imemReq=1 at the old address. On ack, discard rdata, set imemAddr<=pc (the branch target) and go to REQ.
  - SKID: imemReq=0.
    - redirect: skid discarded; imemAddr<=brTarget; go to REQ.
    - ~stall & ~redirect: IF/ID<=skid; imemAddr<=pc; go to REQ.
    - stall: hold.
- Stall: IF/ID holds its contents and ifValid whenever stall=1, in every state.
- Latency and throughput:
  - Data acked in cycle N appears on ifInstr in cycle N+1.
  - With same-cycle ack, one instruction per cycle is sustained.
- Address arithmetic: modulo 2^ADDR_W, so the PC wraps silently.
- ifFlush: registered pulse, deasserted the following cycle unless another redirect is accepted.

Decomposition:
- Shared header/package holds:
  - FSM state encodings IDLE/REQ/DRAIN/SKID.
  - NOP_INSTR default.
  - brCond/brTarget interface width constants, shared with the condition checker and the ID stage.
- One sub-module: fetch_skid_buffer.
  - One entry {instr, pc, valid}.
  - load, unload and clear inputs; clear has priority over load.

Test Plan:
- Reset release, imemAck tied to imemReq: imemAddr 0,1,2,3 on consecutive cycles; ifPc 0,1,2 with ifValid=1 from the third cycle; redirectCount=0.
- ifValid=1, ifPc=2, brCond=1, brTarget=0x40, stall=0 -> next cycle ifValid=0, ifFlush=1, imemAddr=0x40, redirectCount=1. Data for addr 3 never reaches IF/ID; ifPc=0x40 two cycles later.
- Ack latency 3 with request to addr 5 outstanding; taken branch to 0x80 -> imemReq stays high on 5 until ack, data dropped, then request 0x80; ifPc never equals 5.
- stall=1 for 3 cycles with ack arriving mid-stall -> imemReq drops, IF/ID holds its old instr. When stall falls, IF/ID gets the buffered instr and the next request is at buffered pc+1; no loss or duplicate.
- brCond=1 with stall=1, and separately brCond=1 with ifValid=0 -> no redirect, ifFlush=0, redirectCount unchanged.
- rst asserted mid-DRAIN -> same cycle imemReq=0, ifValid=0, redirectCount=0. After release: IDLE for one cycle, then first request at RESET_PC; with counter preloaded to all-ones, a further redirect leaves it saturated.

Source files
------------

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch/redirect path: FSM encodings, branch
// interface widths used by the ID stage and condition checker, NOP default.
package fetch_redirect_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    SKID  = 2'd3
  } fetchState_e;

  localparam int BR_ADDR_W = 32;
  localparam int INSTR_W   = 32;

  localparam logic [INSTR_W-1:0] DEFAULT_NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_redirect_unit_skid_buffer.sv
// One-entry holding slot for an instruction that returned while IF/ID was
// stalled. Clear wins over load so a redirect always discards wrong-path data.
module fetch_skid_buffer
  import fetch_redirect_unit_pkg::*;
#(
  parameter int                ADDR_W    = BR_ADDR_W,
  parameter int                DATA_W    = INSTR_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DEFAULT_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [DATA_W-1:0] loadInstr,
  input  logic [ADDR_W-1:0] loadPc,
  output logic [DATA_W-1:0] skidInstr,
  output logic [ADDR_W-1:0] skidPc,
  output logic              skidValid
);

  // Single entry storage with clear > load > unload priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skidInstr <= NOP_INSTR;
      skidPc    <= '0;
      skidValid <= 1'b0;
    end else if (clear) begin
      skidInstr <= NOP_INSTR;
      skidValid <= 1'b0;
    end else if (load) begin
      skidInstr <= loadInstr;
      skidPc    <= loadPc;
      skidValid <= 1'b1;
    end else if (unload) begin
      skidValid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Owns the PC and the imem fetch handshake, fills IF/ID, and applies taken
// branches from ID by redirecting the PC and squashing the wrong-path fetch.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int                ADDR_W    = BR_ADDR_W,
  parameter int                DATA_W    = INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(1'b1),
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DEFAULT_NOP),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              brCond,
  input  logic [ADDR_W-1:0] brTarget,
  input  logic              stall,
  input  logic              imemAck,
  input  logic [DATA_W-1:0] imemRdata,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  output logic [DATA_W-1:0] ifInstr,
  output logic [ADDR_W-1:0] ifPc,
  output logic              ifValid,
  output logic              ifFlush,
  output logic [CNT_W-1:0]  redirectCount
);

  fetchState_e       stateR, nextStateS;
  logic [ADDR_W-1:0] pcR, pcNextS, addrNextS, ifPcNextS;
  logic [DATA_W-1:0] ifInstrNextS;
  logic              ifValidNextS, reqNextS, redirectS;
  logic              skidLoadS, skidUnloadS;
  logic [CNT_W-1:0]  cntNextS;
  logic [DATA_W-1:0] skidInstrS;
  logic [ADDR_W-1:0] skidPcS;
  logic              skidValidS;

  assign redirectS = brCond & ifValid & ~stall;

  fetch_skid_buffer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NOP_INSTR(NOP_INSTR)
  ) uSkid (
    .clk      (clk),
    .rst      (rst),
    .load     (skidLoadS),
    .unload   (skidUnloadS),
    .clear    (redirectS),
    .loadInstr(imemRdata),
    .loadPc   (imemAddr),
    .skidInstr(skidInstrS),
    .skidPc   (skidPcS),
    .skidValid(skidValidS)
  );

  // Next-state, fetch address and IF/ID update selection.
  always_comb begin
    nextStateS   = stateR;
    pcNextS      = redirectS ? brTarget : pcR;
    addrNextS    = imemAddr;
    ifInstrNextS = ifInstr;
    ifPcNextS    = ifPc;
    ifValidNextS = ifValid;
    skidLoadS    = 1'b0;
    skidUnloadS  = 1'b0;
    case (stateR)
      IDLE: begin
        nextStateS = REQ;
        addrNextS  = pcR;
      end
      REQ: begin
        if (imemAck) begin
          if (redirectS) begin
            addrNextS = brTarget;
          end else if (stall) begin
            skidLoadS  = 1'b1;
            pcNextS    = imemAddr + PC_STEP;
            nextStateS = SKID;
          end else begin
            ifInstrNextS = imemRdata;
            ifPcNextS    = imemAddr;
            ifValidNextS = 1'b1;
            pcNextS      = imemAddr + PC_STEP;
            addrNextS    = imemAddr + PC_STEP;
          end
        end else if (redirectS) begin
          // Request stays up at the old address until imem answers it.
          nextStateS = DRAIN;
        end else if (!stall) begin
          ifValidNextS = 1'b0;
          ifInstrNextS = NOP_INSTR;
        end else begin
          nextStateS = REQ;
        end
      end
      DRAIN: begin
        if (imemAck) begin
          addrNextS  = pcNextS;
          nextStateS = REQ;
        end else begin
          nextStateS = DRAIN;
        end
      end
      SKID: begin
        if (redirectS) begin
          addrNextS  = brTarget;
          nextStateS = REQ;
        end else if (!stall) begin
          skidUnloadS  = 1'b1;
          ifInstrNextS = skidInstrS;
          ifPcNextS    = skidPcS;
          ifValidNextS = skidValidS;
          addrNextS    = pcR;
          nextStateS   = REQ;
        end else begin
          nextStateS = SKID;
        end
      end
      default: begin
        nextStateS = IDLE;
      end
    endcase
    // A taken branch always squashes whatever IF/ID would otherwise receive.
    ifValidNextS = ifValidNextS & ~redirectS;
    ifInstrNextS = redirectS ? NOP_INSTR : ifInstrNextS;
    reqNextS     = (nextStateS == REQ) || (nextStateS == DRAIN);
    cntNextS     = (redirectS && (redirectCount != {CNT_W{1'b1}}))
                   ? redirectCount + CNT_W'(1'b1) : redirectCount;
  end

  // State, PC, fetch request and IF/ID registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR        <= IDLE;
      pcR           <= RESET_PC;
      imemAddr      <= RESET_PC;
      imemReq       <= 1'b0;
      ifInstr       <= NOP_INSTR;
      ifPc          <= '0;
      ifValid       <= 1'b0;
      ifFlush       <= 1'b0;
      redirectCount <= '0;
    end else begin
      stateR        <= nextStateS;
      pcR           <= pcNextS;
      imemAddr      <= addrNextS;
      imemReq       <= reqNextS;
      ifInstr       <= ifInstrNextS;
      ifPc          <= ifPcNextS;
      ifValid       <= ifValidNextS;
      ifFlush       <= redirectS;
      redirectCount <= cntNextS;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed cycle-by-cycle vectors for fetch_redirect_unit against a small
// imem model whose ack latency is set per vector.
module tb_fetch_redirect_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          brCond = 1'b0;
  logic [AW-1:0] brTarget = '0;
  logic          stall = 1'b0;
  logic          imemAck;
  logic [DW-1:0] imemRdata;
  logic          imemReq;
  logic [AW-1:0] imemAddr;
  logic [DW-1:0] ifInstr;
  logic [AW-1:0] ifPc;
  logic          ifValid;
  logic          ifFlush;
  logic [CW-1:0] redirectCount;

  int unsigned ackLat = 0;
  int unsigned waitCnt;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int unsigned   lat;
    logic          bc;
    logic [AW-1:0] bt;
    logic          st;
    logic          eReq;
    logic [AW-1:0] eAddr;
    logic          eValid;
    logic [AW-1:0] ePc;
    logic          eFlush;
    logic [CW-1:0] eCnt;
  } vec_t;

  vec_t vecs[$];

  fetch_redirect_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .brCond(brCond), .brTarget(brTarget), .stall(stall),
    .imemAck(imemAck), .imemRdata(imemRdata), .imemReq(imemReq), .imemAddr(imemAddr),
    .ifInstr(ifInstr), .ifPc(ifPc), .ifValid(ifValid), .ifFlush(ifFlush),
    .redirectCount(redirectCount)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] instrFor(input logic [AW-1:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imemRdata = instrFor(imemAddr);
  assign imemAck   = imemReq && (waitCnt >= ackLat);

  always @(posedge clk or posedge rst) begin
    if (rst) waitCnt <= 0;
    else if (!imemReq || imemAck) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  function automatic vec_t mk(input int unsigned lat, input logic bc, input logic [AW-1:0] bt,
                              input logic st, input logic eReq, input logic [AW-1:0] eAddr,
                              input logic eValid, input logic [AW-1:0] ePc, input logic eFlush,
                              input logic [CW-1:0] eCnt);
    vec_t v;
    v.lat = lat; v.bc = bc; v.bt = bt; v.st = st; v.eReq = eReq; v.eAddr = eAddr;
    v.eValid = eValid; v.ePc = ePc; v.eFlush = eFlush; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic chk(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", what, idx, act, exp);
    end
  endtask

  // Drive one vector just after an edge, clock once, compare outputs.
  task automatic runVec(input int idx, input vec_t v);
    ackLat   = v.lat;
    brCond   = v.bc;
    brTarget = v.bt;
    stall    = v.st;
    @(posedge clk);
    #1;
    chk("imemReq", idx, 32'(imemReq), 32'(v.eReq));
    chk("imemAddr", idx, imemAddr, v.eAddr);
    chk("ifValid", idx, 32'(ifValid), 32'(v.eValid));
    chk("ifFlush", idx, 32'(ifFlush), 32'(v.eFlush));
    chk("redirectCount", idx, 32'(redirectCount), 32'(v.eCnt));
    if (v.eValid) begin
      chk("ifPc", idx, ifPc, v.ePc);
      chk("ifInstr", idx, ifInstr, instrFor(v.ePc));
    end else begin
      chk("ifInstrNop", idx, ifInstr, 32'h0000_0000);
    end
  endtask

  initial begin
    //            lat  bc    bt            st    req   addr          val   pc            fl    cnt
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1,        1'b1, 32'h0,        1'b0, 3'd0));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2,        1'b1, 32'h1,        1'b0, 3'd0));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h3,        1'b1, 32'h2,        1'b0, 3'd0));
    vecs.push_back(mk(0, 1'b1, 32'h40,       1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        1'b1, 3'd1));
    vecs.push_back(mk(0, 1'b1, 32'h99,       1'b0, 1'b1, 32'h41,       1'b1, 32'h40,       1'b0, 3'd1));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h42,       1'b1, 32'h41,       1'b0, 3'd1));
    vecs.push_back(mk(0, 1'b1, 32'h77,       1'b1, 1'b0, 32'h42,       1'b1, 32'h41,       1'b0, 3'd1));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h42,       1'b1, 32'h41,       1'b0, 3'd1));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h43,       1'b1, 32'h42,       1'b0, 3'd1));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h44,       1'b1, 32'h43,       1'b0, 3'd1));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h44,       1'b1, 32'h43,       1'b0, 3'd1));
    vecs.push_back(mk(0, 1'b1, 32'h10,       1'b0, 1'b1, 32'h10,       1'b0, 32'h0,        1'b1, 3'd2));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h11,       1'b1, 32'h10,       1'b0, 3'd2));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h11,       1'b1, 32'h10,       1'b0, 3'd2));
    vecs.push_back(mk(0, 1'b1, 32'h55,       1'b1, 1'b0, 32'h11,       1'b1, 32'h10,       1'b0, 3'd2));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h12,       1'b1, 32'h11,       1'b0, 3'd2));
    vecs.push_back(mk(0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, 3'd3));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 3'd3));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1,        1'b1, 32'h0,        1'b0, 3'd3));
    // ack arrives in the middle of a three-cycle stall
    vecs.push_back(mk(1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1,        1'b1, 32'h0,        1'b0, 3'd3));
    vecs.push_back(mk(1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1,        1'b1, 32'h0,        1'b0, 3'd3));
    vecs.push_back(mk(1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1,        1'b1, 32'h0,        1'b0, 3'd3));
    vecs.push_back(mk(1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2,        1'b1, 32'h1,        1'b0, 3'd3));
    vecs.push_back(mk(1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2,        1'b0, 32'h0,        1'b0, 3'd3));
    vecs.push_back(mk(1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h3,        1'b1, 32'h2,        1'b0, 3'd3));
    // branch while the request to 5 is outstanding with latency 3
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b1, 32'h3,        1'b0, 3'd3));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h5,        1'b1, 32'h4,        1'b0, 3'd3));
    vecs.push_back(mk(3, 1'b1, 32'h80,       1'b0, 1'b1, 32'h5,        1'b0, 32'h0,        1'b1, 3'd4));
    vecs.push_back(mk(3, 1'b1, 32'h99,       1'b0, 1'b1, 32'h5,        1'b0, 32'h0,        1'b0, 3'd4));
    vecs.push_back(mk(3, 1'b0, 32'h0,        1'b0, 1'b1, 32'h5,        1'b0, 32'h0,        1'b0, 3'd4));
    vecs.push_back(mk(3, 1'b0, 32'h0,        1'b0, 1'b1, 32'h80,       1'b0, 32'h0,        1'b0, 3'd4));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h81,       1'b1, 32'h80,       1'b0, 3'd4));
    // drive the counter into saturation
    vecs.push_back(mk(0, 1'b1, 32'h100,      1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        1'b1, 3'd5));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h101,      1'b1, 32'h100,      1'b0, 3'd5));
    vecs.push_back(mk(0, 1'b1, 32'h200,      1'b0, 1'b1, 32'h200,      1'b0, 32'h0,        1'b1, 3'd6));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h201,      1'b1, 32'h200,      1'b0, 3'd6));
    vecs.push_back(mk(0, 1'b1, 32'h300,      1'b0, 1'b1, 32'h300,      1'b0, 32'h0,        1'b1, 3'd7));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h301,      1'b1, 32'h300,      1'b0, 3'd7));
    vecs.push_back(mk(0, 1'b1, 32'h400,      1'b0, 1'b1, 32'h400,      1'b0, 32'h0,        1'b1, 3'd7));
    vecs.push_back(mk(0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h401,      1'b1, 32'h400,      1'b0, 3'd7));

    #2 rst = 1'b1;
    #1;
    chk("rstReq", 0, 32'(imemReq), 32'h0);
    chk("rstAddr", 0, imemAddr, 32'h0);
    chk("rstValid", 0, 32'(ifValid), 32'h0);
    chk("rstInstr", 0, ifInstr, 32'h0);
    chk("rstPc", 0, ifPc, 32'h0);
    chk("rstFlush", 0, 32'(ifFlush), 32'h0);
    chk("rstCnt", 0, 32'(redirectCount), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    foreach (vecs[i]) runVec(i + 1, vecs[i]);

    // Enter DRAIN with a saturated counter, then reset asynchronously mid-DRAIN.
    runVec(100, mk(3, 1'b1, 32'h500, 1'b0, 1'b1, 32'h401, 1'b0, 32'h0, 1'b1, 3'd7));
    runVec(101, mk(3, 1'b0, 32'h0,   1'b0, 1'b1, 32'h401, 1'b0, 32'h0, 1'b0, 3'd7));
    #2 rst = 1'b1;
    #1;
    chk("midRstReq", 102, 32'(imemReq), 32'h0);
    chk("midRstValid", 102, 32'(ifValid), 32'h0);
    chk("midRstCnt", 102, 32'(redirectCount), 32'h0);
    chk("midRstAddr", 102, imemAddr, 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    ackLat = 0;
    #1;
    chk("idleReq", 103, 32'(imemReq), 32'h0);
    runVec(104, mk(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 3'd0));
    runVec(105, mk(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b1, 32'h0, 1'b0, 3'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
